// File: rtl/icache_ahb_refill_if.sv
// Bundles the cache miss port and the AHB-Lite bus seen by the refill engine.
// master = the refill engine; slave = its environment (the cache plus the AHB slave).
interface icache_ahb_refill_if;
  // Handshakes:
  // - Cache side: mem_req is a level request, sampled only while the engine is idle.
  //   mem_ready is a one-cycle pulse that completes the request; mem_data_in and
  //   mem_err are valid in that cycle.
  // - Bus side: an AHB transfer phase advances only in a cycle with hready=1.
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data_in;
  logic         mem_ready;
  logic         mem_err;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic [2:0]   hsize;
  logic         hwrite;
  logic [3:0]   hprot;
  logic         hready;
  logic         hresp;
  logic [31:0]  hrdata;

  modport master (
    input  mem_req, mem_addr, hready, hresp, hrdata,
    output mem_data_in, mem_ready, mem_err,
    output haddr, htrans, hburst, hsize, hwrite, hprot
  );

  modport slave (
    output mem_req, mem_addr, hready, hresp, hrdata,
    input  mem_data_in, mem_ready, mem_err,
    input  haddr, htrans, hburst, hsize, hwrite, hprot
  );
endinterface

// File: rtl/icache_ahb_refill.sv
// I-cache line refill engine: fetches one 16-byte line as an AHB INCR4 read burst
// and returns it to the cache as a 128-bit line with a one-cycle ready pulse.
module icache_ahb_refill #(
  parameter logic [3:0] HPROT_VAL = 4'b0010
) (
  input  logic                       clk,
  input  logic                       rst,
  icache_ahb_refill_if.master        bus,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_BURST = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  state_e         state_q, state_d;
  logic [27:0]    base_q, base_d;
  logic [1:0]     acnt_q, acnt_d;
  logic [1:0]     dcnt_q, dcnt_d;
  logic [127:0]   line_q, line_d;
  logic [31:0]    haddr_q, haddr_d;
  logic [1:0]     htrans_q, htrans_d;
  logic           ready_q, ready_d;
  logic           err_q, err_d;

  // The line offset of the miss address is irrelevant: the whole line is fetched.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.mem_addr[3:0];

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    acnt_d   = acnt_q;
    dcnt_d   = dcnt_q;
    line_d   = line_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        htrans_d = HT_IDLE;
        if (bus.mem_req) begin
          base_d   = bus.mem_addr[31:4];
          line_d   = '0;
          acnt_d   = 2'd0;
          dcnt_d   = 2'd0;
          haddr_d  = {bus.mem_addr[31:4], 4'b0000};
          htrans_d = HT_NONSEQ;
          state_d  = S_ADDR;
        end
      end

      S_ADDR: begin
        if (bus.hready) begin
          acnt_d   = 2'd1;
          haddr_d  = {base_q, 2'd1, 2'b00};
          htrans_d = HT_SEQ;
          state_d  = S_BURST;
        end else if (bus.hresp) begin
          htrans_d = HT_IDLE;
          state_d  = S_ERR;
        end
      end

      S_BURST: begin
        if (bus.hready) begin
          line_d[{dcnt_q, 5'd0} +: 32] = bus.hrdata;
          dcnt_d = dcnt_q + 2'd1;
          acnt_d = acnt_q + 2'd1;
          // acnt_q==3 means the last beat's address is being accepted now.
          if (acnt_q == 2'd3) begin
            htrans_d = HT_IDLE;
            state_d  = S_DRAIN;
          end else begin
            haddr_d  = {base_q, acnt_q + 2'd1, 2'b00};
          end
        end else if (bus.hresp) begin
          htrans_d = HT_IDLE;
          state_d  = S_ERR;
        end
      end

      S_DRAIN: begin
        if (bus.hready) begin
          line_d[{dcnt_q, 5'd0} +: 32] = bus.hrdata;
          dcnt_d  = dcnt_q + 2'd1;
          ready_d = 1'b1;
          state_d = S_DONE;
        end else if (bus.hresp) begin
          state_d = S_ERR;
        end
      end

      // Second ERROR response cycle: its data is not meaningful and is dropped.
      S_ERR: begin
        htrans_d = HT_IDLE;
        if (bus.hready) begin
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        htrans_d = HT_IDLE;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      acnt_q   <= '0;
      dcnt_q   <= '0;
      line_q   <= '0;
      haddr_q  <= '0;
      htrans_q <= HT_IDLE;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      acnt_q   <= acnt_d;
      dcnt_q   <= dcnt_d;
      line_q   <= line_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign bus.mem_data_in = line_q;
  assign bus.mem_ready   = ready_q;
  assign bus.mem_err     = err_q;
  assign bus.haddr       = haddr_q;
  assign bus.htrans      = htrans_q;
  assign bus.hburst      = 3'b011;
  assign bus.hsize       = 3'b010;
  assign bus.hwrite      = 1'b0;
  assign bus.hprot       = HPROT_VAL;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_icache_ahb_refill.sv
// Directed bench for icache_ahb_refill: per-cycle vector table plus a reset-abort sequence;
// every returned line is also checked against an expected queue.
module tb_icache_ahb_refill;

  localparam logic [1:0]  HI = 2'b00;
  localparam logic [1:0]  HN = 2'b10;
  localparam logic [1:0]  HS = 2'b11;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;
  localparam logic [10:0] CONSTS = {3'b011, 3'b010, 1'b0, 4'b0010};

  typedef struct {
    logic         req;
    logic [31:0]  addr;
    logic         hready;
    logic         hresp;
    logic [31:0]  hrdata;
    logic [1:0]   e_htrans;
    logic [31:0]  e_haddr;
    logic         chk_addr;
    logic         e_ready;
    logic         e_err;
    logic         chk_data;
    logic [127:0] e_data;
  } vec_t;

  logic clk;
  logic rst;
  logic [2:0] dbg_state;
  icache_ahb_refill_if bus_if ();

  icache_ahb_refill #(.HPROT_VAL(4'b0010)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  logic [128:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic req, input logic [31:0] addr, input logic hready,
                     input logic hresp, input logic [31:0] hrdata, input logic [1:0] e_htrans,
                     input logic [31:0] e_haddr, input logic chk_addr, input logic e_ready,
                     input logic e_err, input logic chk_data, input logic [127:0] e_data);
    vec_t v;
    v.req = req; v.addr = addr; v.hready = hready; v.hresp = hresp; v.hrdata = hrdata;
    v.e_htrans = e_htrans; v.e_haddr = e_haddr; v.chk_addr = chk_addr;
    v.e_ready = e_ready; v.e_err = e_err; v.chk_data = chk_data; v.e_data = e_data;
    vecs.push_back(v);
    if (e_ready) exp_q.push_back({e_err, e_data});
  endtask

  // Zero-wait refill: cycle 0 samples the request, mem_ready lands in cycle 6.
  task automatic add_zw(input logic [31:0] addr, input logic [31:0] wbase,
                        input logic [127:0] prev_line);
    logic [31:0] b;
    logic [31:0] w0, w1, w2, w3;
    b = {addr[31:4], 4'h0};
    w0 = wbase; w1 = wbase + 1; w2 = wbase + 2; w3 = wbase + 3;
    add(1, addr, 1, 0, JUNK, HI, 0,      0, 0, 0, 1, prev_line);
    add(1, addr, 1, 0, JUNK, HN, b,      1, 0, 0, 1, 128'h0);
    add(1, addr, 1, 0, w0,   HS, b + 4,  1, 0, 0, 1, 128'h0);
    add(1, addr, 1, 0, w1,   HS, b + 8,  1, 0, 0, 1, {96'h0, w0});
    add(1, addr, 1, 0, w2,   HS, b + 12, 1, 0, 0, 1, {64'h0, w1, w0});
    add(1, addr, 1, 0, w3,   HI, 0,      0, 0, 0, 1, {32'h0, w2, w1, w0});
    add(1, addr, 1, 0, JUNK, HI, 0,      0, 1, 0, 1, {w3, w2, w1, w0});
  endtask

  // driver: inputs applied just after the rising edge, outputs checked on the falling edge
  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      bus_if.mem_req  = vecs[i].req;
      bus_if.mem_addr = vecs[i].addr;
      bus_if.hready   = vecs[i].hready;
      bus_if.hresp    = vecs[i].hresp;
      bus_if.hrdata   = vecs[i].hrdata;
      @(negedge clk);
      chk($sformatf("htrans[%0d]", i), {127'h0, bus_if.htrans}, {127'h0, vecs[i].e_htrans});
      chk($sformatf("mem_ready[%0d]", i), {128'h0, bus_if.mem_ready}, {128'h0, vecs[i].e_ready});
      chk($sformatf("mem_err[%0d]", i), {128'h0, bus_if.mem_err}, {128'h0, vecs[i].e_err});
      chk($sformatf("consts[%0d]", i),
          {118'h0, bus_if.hburst, bus_if.hsize, bus_if.hwrite, bus_if.hprot}, {118'h0, CONSTS});
      if (vecs[i].chk_addr)
        chk($sformatf("haddr[%0d]", i), {97'h0, bus_if.haddr}, {97'h0, vecs[i].e_haddr});
      if (vecs[i].chk_data)
        chk($sformatf("mem_data_in[%0d]", i), {1'b0, bus_if.mem_data_in}, {1'b0, vecs[i].e_data});
    end
    vecs.delete();
  endtask

  // scoreboard: every mem_ready pulse must match the next expected {err, line}
  always @(negedge clk) begin
    if (rst === 1'b1 && bus_if.mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: unexpected mem_ready, got %h expected none",
                 {bus_if.mem_err, bus_if.mem_data_in});
      end else begin
        chk("scoreboard", {bus_if.mem_err, bus_if.mem_data_in}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [127:0] line_a, line_b, line_e, line_d;
    line_a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    line_b = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    line_e = {32'h0, 32'h0, 32'hC1, 32'hC0};
    line_d = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

    rst = 1'b0;
    bus_if.mem_req = 1'b0;
    bus_if.mem_addr = '0;
    bus_if.hready = 1'b1;
    bus_if.hresp = 1'b0;
    bus_if.hrdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_htrans", {127'h0, bus_if.htrans}, {127'h0, HI});
    chk("rst_haddr", {97'h0, bus_if.haddr}, 129'h0);
    chk("rst_ready_err", {127'h0, bus_if.mem_ready, bus_if.mem_err}, 129'h0);
    chk("rst_data", {1'b0, bus_if.mem_data_in}, 129'h0);
    chk("rst_consts", {118'h0, bus_if.hburst, bus_if.hsize, bus_if.hwrite, bus_if.hprot},
        {118'h0, CONSTS});
    chk("rst_state", {126'h0, dbg_state}, 129'h0);
    #1 rst = 1'b1;

    // zero-wait refill at 0x1234
    add_zw(32'h0000_1234, 32'hA0, 128'h0);
    add(0, 0, 1, 0, JUNK, HI, 0, 0, 0, 0, 1, line_a);

    // wait states: two on beat 1, one on beat 3
    add(1, 32'h567C, 1, 0, JUNK,  HI, 0,       0, 0, 0, 1, line_a);
    add(1, 32'h567C, 1, 0, JUNK,  HN, 32'h5670, 1, 0, 0, 1, 128'h0);
    add(1, 32'h567C, 1, 0, 32'hB0, HS, 32'h5674, 1, 0, 0, 1, 128'h0);
    add(1, 32'h567C, 0, 0, JUNK,  HS, 32'h5678, 1, 0, 0, 1, {96'h0, 32'hB0});
    add(1, 32'h567C, 0, 0, JUNK,  HS, 32'h5678, 1, 0, 0, 1, {96'h0, 32'hB0});
    add(1, 32'h567C, 1, 0, 32'hB1, HS, 32'h5678, 1, 0, 0, 1, {96'h0, 32'hB0});
    add(1, 32'h567C, 1, 0, 32'hB2, HS, 32'h567C, 1, 0, 0, 1, {64'h0, 32'hB1, 32'hB0});
    add(1, 32'h567C, 0, 0, JUNK,  HI, 0,       0, 0, 0, 1, {32'h0, 32'hB2, 32'hB1, 32'hB0});
    add(1, 32'h567C, 1, 0, 32'hB3, HI, 0,       0, 0, 0, 1, {32'h0, 32'hB2, 32'hB1, 32'hB0});
    add(1, 32'h567C, 1, 0, JUNK,  HI, 0,       0, 1, 0, 1, line_b);
    add(0, 0,        1, 0, JUNK,  HI, 0,       0, 0, 0, 1, line_b);

    // ERROR on beat 2; mem_req also drops mid-burst, which must not matter
    add(1, 32'h0904, 1, 0, JUNK,  HI, 0,       0, 0, 0, 1, line_b);
    add(1, 32'h0904, 1, 0, JUNK,  HN, 32'h0900, 1, 0, 0, 1, 128'h0);
    add(0, 0,        1, 0, 32'hC0, HS, 32'h0904, 1, 0, 0, 1, 128'h0);
    add(0, 0,        1, 0, 32'hC1, HS, 32'h0908, 1, 0, 0, 1, {96'h0, 32'hC0});
    add(0, 0,        0, 1, JUNK,  HS, 32'h090C, 1, 0, 0, 1, line_e);
    add(0, 0,        1, 1, JUNK,  HI, 0,       0, 0, 0, 1, line_e);
    add(0, 0,        1, 0, JUNK,  HI, 0,       0, 1, 1, 1, line_e);
    add(0, 0,        1, 0, JUNK,  HI, 0,       0, 0, 0, 1, line_e);

    // back-to-back: drop for one cycle after mem_ready, then request 0x2000
    add_zw(32'h0000_1000, 32'hD0, line_e);
    add(0, 0, 1, 0, JUNK, HI, 0, 0, 0, 0, 1, line_d);
    add_zw(32'h0000_2004, 32'hE0, line_d);
    add(0, 0, 1, 0, JUNK, HI, 0, 0, 0, 0, 1, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
    run_vecs();

    // reset asserted during beat 1 of a refill at 0x3000
    @(posedge clk); #1;
    bus_if.mem_req = 1'b1; bus_if.mem_addr = 32'h3000; bus_if.hready = 1'b1; bus_if.hrdata = JUNK;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_if.hrdata = 32'h11;
    @(posedge clk); #1;
    bus_if.hrdata = 32'h22;
    chk("pre_abort_htrans", {127'h0, bus_if.htrans}, {127'h0, HS});
    #2 rst = 1'b0;
    #1;
    chk("abort_htrans", {127'h0, bus_if.htrans}, {127'h0, HI});
    chk("abort_ready", {128'h0, bus_if.mem_ready}, 129'h0);
    chk("abort_haddr", {97'h0, bus_if.haddr}, 129'h0);
    chk("abort_data", {1'b0, bus_if.mem_data_in}, 129'h0);
    chk("abort_state", {126'h0, dbg_state}, 129'h0);
    bus_if.mem_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // recovery: request at 0x40 completes normally
    add_zw(32'h0000_0040, 32'hF0, 128'h0);
    add(0, 0, 1, 0, JUNK, HI, 0, 0, 0, 0, 1, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    run_vecs();

    repeat (2) @(negedge clk);
    chk("exp_q_empty", 129'(exp_q.size()), 129'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_ahb_refill.md
# icache_ahb_refill

Line-refill engine between the I-cache miss port and the AHB-Lite system bus. When the cache raises `mem_req`, it fetches the 16-byte line containing `mem_addr` as one INCR4 read burst. It assembles the four words into a 128-bit line and returns it on `mem_data_in` with a one-cycle `mem_ready` pulse. It is the responder for the cache's `mem_req`/`mem_ready` interface and the AHB initiator on the bus side.

## Interface
- `HPROT_VAL`, 4'b0010: constant driven on `hprot` (opcode fetch, privileged, non-bufferable, non-cacheable).
- `clk` input 1: single clock; every register is clocked on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `mem_req` input 1: refill request from the cache, level signal.
- `mem_addr` input 32: miss address; bits [3:0] are ignored.
- `mem_data_in` output 128: returned line; word k sits at bits [32k+31:32k], fetched from base+4k.
- `mem_ready` output 1: one-cycle pulse; `mem_data_in` is valid in that cycle.
- `mem_err` output 1: asserted together with `mem_ready` when the burst ended in an AHB ERROR.
- `haddr` output 32: AHB address.
- `htrans` output 2: IDLE=2'b00, NONSEQ=2'b10, SEQ=2'b11.
- `hburst` output 3: constant 3'b011 (INCR4).
- `hsize` output 3: constant 3'b010 (word).
- `hwrite` output 1: constant 0.
- `hprot` output 4: constant `HPROT_VAL`.
- `hready` input 1: AHB transfer done / wait.
- `hresp` input 1: 0=OKAY, 1=ERROR.
- `hrdata` input 32: AHB read data.

## Operation
- States: IDLE, ADDR, BURST, DRAIN, ERR, DONE.
- **IDLE.** `htrans`=IDLE.
  - If `mem_req`=1: latch base = {`mem_addr`[31:4], 4'b0}, clear the line register to 0, clear `acnt` and `dcnt`, then go to ADDR.
- **ADDR.** Drives `haddr`=base and `htrans`=NONSEQ.
  - If `hready`=1: `acnt`=1, go to BURST.
- **BURST.** Drives `haddr`=base+4·`acnt` and `htrans`=SEQ.
  - Each cycle with `hready`=1: capture `hrdata` into word `dcnt`, `dcnt`++, `acnt`++.
  - When the 4th address is accepted: go to DRAIN.
- **DRAIN.** `htrans`=IDLE.
  - On `hready`=1: capture word 3, go to DONE.
- **DONE.** `mem_ready`=1 for exactly one cycle, `mem_err` as recorded, then go to IDLE.
  - `mem_req` is ignored in DONE.
  - The cache drops `mem_req` in the cycle after `mem_ready`; a `mem_req` still high in IDLE is a new request.
- **Error.** In ADDR, BURST or DRAIN, `hresp`=1 with `hready`=0 is the first cycle of an ERROR response.
  - Next state is ERR, where `htrans`=IDLE (remaining beats cancelled).
  - ERR waits for `hready`=1 (second response cycle), sets the error flag, discards that beat's data, and goes to DONE.
  - Words not captured read as 0 in `mem_data_in`.
- `haddr` arithmetic: increment bits [3:2] only; bits [31:4] stay at base; bits [1:0] are always 0.
- `mem_data_in` is held stable from DONE until the next request acceptance.

## Timing
- Reset values:
  - `htrans`=IDLE, `haddr`=0, `mem_ready`=0, `mem_err`=0, `mem_data_in`=0.
  - State IDLE, counters 0.
  - Constant outputs are at their constant values.
- All outputs are registered.
- Zero-wait latency, counting cycle 0 as the IDLE cycle that samples `mem_req`:
  - Cycles 1–4: NONSEQ at base, then SEQ at base+4, +8, +12.
  - Cycle 5: IDLE; word 3 is captured.
  - Cycle 6: `mem_ready`.
  - The refill takes 6 cycles plus one cycle per wait state.
- Wait states (`hready`=0): `haddr`, `htrans` and the counters hold; no data is captured.
- `mem_req` falling while the FSM is outside IDLE has no effect; the burst completes and `mem_ready` still pulses.
- Reset asserted mid-burst:
  - All outputs return to reset values immediately, asynchronously.
  - Any in-flight AHB data phase is ignored.
  - No `mem_ready` is produced for the aborted request.

## Test plan
- **Zero-wait refill.** Slave with `hready`=1; `mem_req` at `mem_addr`=0x0000_1234; words 0xA0..0xA3.
  - `haddr` sequence 0x1230/34/38/3C with NONSEQ,SEQ,SEQ,SEQ.
  - `mem_ready` at cycle 6, `mem_data_in`=0x000000A3_000000A2_000000A1_000000A0, `mem_err`=0.
- **Wait states.** Slave inserts 2 waits on beat 1 and 1 wait on beat 3.
  - `haddr`/`htrans` held during waits.
  - `mem_ready` at cycle 9; data correct.
- **Error on beat 2.** OKAY on beats 0–1, two-cycle ERROR on beat 2.
  - `htrans`=IDLE in the second error cycle.
  - `mem_ready`=`mem_err`=1, words 2 and 3 = 0.
- **Back-to-back refills.** `mem_req` dropped after `mem_ready`, re-raised one cycle later at 0x0000_2000.
  - Second NONSEQ at 0x2000.
  - First line stays on `mem_data_in` until the second request is accepted.
- **Reset mid-burst.** `rst`=0 during beat 1.
  - `htrans`=IDLE, `mem_ready`=0 immediately.
  - After release, a new request at 0x40 completes normally.
